// File: rtl/obstacle_manager_if.sv
// Bundles the obstacle_manager control inputs, dino box and obstacle/status outputs.
// With OBS_PAUSE_EN defined the bundle also carries the pause input.
interface obstacle_manager_if #(
    parameter int NUM_OBS = 4
);
    logic                   tick;
    logic                   start;
    logic [1:0]             level;
    logic [9:0]             dino_h;
    logic [9:0]             dino_v;
    logic [7:0]             dino_w;
    logic [7:0]             dino_ht;
    logic [10*NUM_OBS-1:0]  obs_h;
    logic [10*NUM_OBS-1:0]  obs_v;
    logic [NUM_OBS-1:0]     obs_active;
    logic                   alive;
    logic                   collide;
`ifdef OBS_PAUSE_EN
    logic                   pause;

    modport master (
        output tick, start, level, dino_h, dino_v, dino_w, dino_ht, pause,
        input  obs_h, obs_v, obs_active, alive, collide
    );
    modport slave (
        input  tick, start, level, dino_h, dino_v, dino_w, dino_ht, pause,
        output obs_h, obs_v, obs_active, alive, collide
    );
`else
    modport master (
        output tick, start, level, dino_h, dino_v, dino_w, dino_ht,
        input  obs_h, obs_v, obs_active, alive, collide
    );
    modport slave (
        input  tick, start, level, dino_h, dino_v, dino_w, dino_ht,
        output obs_h, obs_v, obs_active, alive, collide
    );
`endif
endinterface

// File: rtl/obstacle_manager.sv
// NUM_OBS obstacle slots: LFSR-scheduled spawns, level-scaled leftward motion, dino AABB collision
// and an IDLE/RUN/DEAD game FSM. Define OBS_PAUSE_EN to add a pause input that masks tick in RUN.
module obstacle_manager #(
    parameter int NUM_OBS    = 4,
    parameter int SPAWN_X    = 640,
    parameter int GROUND_V   = 400,
    parameter int FLY_OFFSET = 40,
    parameter int OBS_W      = 20,
    parameter int OBS_HT     = 30,
    parameter int BASE_SPEED = 2,
    parameter int MIN_GAP    = 24
) (
    input  logic              clk,
    input  logic              rst,
    obstacle_manager_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DEAD = 2'd2} state_t;

    localparam logic [9:0]  L_SPAWN_X  = 10'(SPAWN_X);
    localparam logic [9:0]  L_GROUND_V = 10'(GROUND_V);
    localparam logic [9:0]  L_FLY_V    = 10'(GROUND_V - FLY_OFFSET);
    localparam logic [10:0] L_OBS_W    = 11'(OBS_W);
    localparam logic [10:0] L_OBS_HT   = 11'(OBS_HT);
    localparam logic [9:0]  L_BASE     = 10'(BASE_SPEED);
    localparam logic [7:0]  L_MIN_GAP  = 8'(MIN_GAP);

    state_t                   r_state, w_state_nxt;
    logic [NUM_OBS-1:0][9:0]  r_h, r_v, w_h_nxt, w_v_nxt;
    logic [NUM_OBS-1:0]       r_act, w_act_moved, w_act_nxt, w_hit;
    logic [7:0]               r_lfsr, r_gap_cnt, r_gap_target;
    logic [7:0]               w_gap_inc, w_gap_nxt, w_target_nxt;
    logic [9:0]               w_speed;
    logic                     r_collide;
    logic                     w_tick_en, w_overlap, w_alive, w_run, w_restart, w_step;
    logic                     w_fire, w_found, w_lfsr_fb;

`ifdef OBS_PAUSE_EN
    assign w_tick_en = bus.tick & ~bus.pause;
`else
    assign w_tick_en = bus.tick;
`endif

    assign w_speed   = L_BASE + {8'd0, bus.level};
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Strict overlap, widened to 11 bits so edge sums cannot wrap.
    for (genvar g = 0; g < NUM_OBS; g++) begin : g_hit
        logic [10:0] w_oh, w_ov;
        assign w_oh = {1'b0, r_h[g]};
        assign w_ov = {1'b0, r_v[g]};
        assign w_hit[g] = r_act[g]
            && (w_oh < ({1'b0, bus.dino_h} + {3'b0, bus.dino_w}))
            && ({1'b0, bus.dino_h} < (w_oh + L_OBS_W))
            && (w_ov < ({1'b0, bus.dino_v} + {3'b0, bus.dino_ht}))
            && ({1'b0, bus.dino_v} < (w_ov + L_OBS_HT));
    end
    assign w_overlap = |w_hit;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_overlap) w_state_nxt = S_DEAD;
            S_DEAD:  if (bus.start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_alive   = 1'b1;
        w_run     = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            S_RUN:  w_run = 1'b1;
            S_DEAD: begin
                w_alive   = 1'b0;
                w_restart = bus.start;
            end
            default: ;
        endcase
    end

    // A collision on a tick cycle wins: the position update is dropped.
    assign w_step = w_run & w_tick_en & ~w_overlap;

    always_comb begin
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        w_act_moved = r_act;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (r_act[i]) begin
                if (r_h[i] >= w_speed) w_h_nxt[i] = r_h[i] - w_speed;
                else                   w_act_moved[i] = 1'b0;
            end
        end
        w_act_nxt    = w_act_moved;
        w_gap_inc    = (r_gap_cnt == 8'hFF) ? r_gap_cnt : r_gap_cnt + 8'd1;
        w_fire       = (w_gap_inc >= r_gap_target);
        w_gap_nxt    = w_fire ? 8'd0 : w_gap_inc;
        w_target_nxt = w_fire ? (L_MIN_GAP + {3'b0, r_lfsr[4:0]}) : r_gap_target;
        // Slots freed by this tick's motion are already eligible; the loaded slot is not moved.
        w_found      = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (w_fire && !w_found && !w_act_moved[i]) begin
                w_found      = 1'b1;
                w_h_nxt[i]   = L_SPAWN_X;
                w_v_nxt[i]   = r_lfsr[7] ? L_FLY_V : L_GROUND_V;
                w_act_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr       <= 8'hB8;
            r_h          <= {NUM_OBS{L_SPAWN_X}};
            r_v          <= {NUM_OBS{L_GROUND_V}};
            r_act        <= '0;
            r_gap_cnt    <= 8'd0;
            r_gap_target <= L_MIN_GAP;
            r_collide    <= 1'b0;
        end else begin
            r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
            r_collide <= w_run & w_overlap;
            if (w_restart) begin
                r_h          <= {NUM_OBS{L_SPAWN_X}};
                r_v          <= {NUM_OBS{L_GROUND_V}};
                r_act        <= '0;
                r_gap_cnt    <= 8'd0;
                r_gap_target <= L_MIN_GAP;
            end else if (w_step) begin
                r_h          <= w_h_nxt;
                r_v          <= w_v_nxt;
                r_act        <= w_act_nxt;
                r_gap_cnt    <= w_gap_nxt;
                r_gap_target <= w_target_nxt;
            end
        end
    end

    assign bus.obs_h      = r_h;
    assign bus.obs_v      = r_v;
    assign bus.obs_active = r_act;
    assign bus.alive      = w_alive;
    assign bus.collide    = r_collide;
endmodule

// File: doc/obstacle_manager.md
Name: obstacle_manager

Overview:
Parametrised successor to the fixed obstacle/enemy pair. Manages NUM_OBS independent obstacle slots, each either a ground or a flying type. Owns spawn scheduling with an internal LFSR, leftward motion scaled by level, and dino collision detection. Also runs a small game-state FSM. Sits between clockdiv/counter and the VGA and score blocks, and replaces the separate obstacle, enemy and collisions instances.

Parameters:
NUM_OBS, 4, number of obstacle slots (1..8)
SPAWN_X, 640, obs_h loaded on spawn (left edge, pixels)
GROUND_V, 400, obs_v for ground type
FLY_OFFSET, 40, flying type obs_v = GROUND_V - FLY_OFFSET
OBS_W, 20, obstacle box width
OBS_HT, 30, obstacle box height
BASE_SPEED, 2, pixels per tick at level 0
MIN_GAP, 24, minimum ticks between spawns

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle motion strobe (frame/cactus rate)
start  in  1  level-sensitive start/restart request
level  in  2  speed level from counter
dino_h  in  10  dino left edge
dino_v  in  10  dino top edge
dino_w  in  8  dino box width
dino_ht  in  8  dino box height
obs_h  out  10*NUM_OBS  packed left edges, slot i at [10i+9:10i]
obs_v  out  10*NUM_OBS  packed top edges
obs_active  out  NUM_OBS  slot valid
alive  out  1  high in IDLE/RUN, low in DEAD
collide  out  1  one-cycle pulse on the RUN->DEAD transition

Behaviour:
- Reset: state IDLE. All obs_active=0, obs_h=SPAWN_X, obs_v=GROUND_V. alive=1, collide=0. LFSR=8'hB8, gap_cnt=0, gap_target=MIN_GAP.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk in every state, never all-zero.
- FSM:
  - IDLE: start=1 -> RUN. No motion, no spawn.
  - RUN: motion, spawn and collision are active.
  - DEAD: all registers frozen. start=1 clears all slots, sets gap_cnt=0 and gap_target=MIN_GAP, then -> RUN.
- Motion (RUN, tick=1): speed = BASE_SPEED + level, computed at 10 bits.
  - Active slot with obs_h >= speed: obs_h -= speed.
  - Active slot with obs_h < speed: obs_active=0. No wrap-around ever.
- Spawn (RUN, tick=1): gap_cnt increments, saturating at 255.
  - When gap_cnt >= gap_target, the lowest-indexed inactive slot is loaded: obs_h=SPAWN_X. obs_v=GROUND_V if lfsr[7]=0, else GROUND_V-FLY_OFFSET. active=1.
  - On spawn: gap_cnt=0, gap_target = MIN_GAP + lfsr[4:0].
  - All slots full: spawn dropped, gap_cnt=0, gap_target reloaded.
  - A slot freed and spawned on the same tick is available for that spawn. A newly spawned slot is not moved on its spawn tick.
- Collision: combinational AABB overlap, per active slot, between the registered obs box (OBS_W x OBS_HT) and the dino box. Overlap is strict, so touching edges do not count.
  - In RUN, any overlap -> DEAD on the next edge. Latency is 1 clk from registered positions.
  - collide pulses high for exactly that 1 clk. alive falls on the same edge.
  - Overlap in IDLE/DEAD is ignored.
- Simultaneous events:
  - Collision and tick in the same cycle: DEAD wins, and the positions update on that tick is suppressed.
  - start while in RUN: ignored.
  - rst overrides everything, including mid-motion.

Optional Feature:
OBS_PAUSE_EN: adds input port pause (1 bit). While pause=1 in RUN, tick is ignored: no motion, no spawn, gap_cnt held. Collision checking continues. Without the macro, there is no pause port and tick always applies in RUN.

Test Plan:
- Reset then start=1 for 1 clk -> state RUN, alive=1, obs_active=0; no spawn before 24 ticks (MIN_GAP=24).
- RUN, level=3, one active slot at obs_h=100, tick -> obs_h=95; at obs_h=4 the next tick -> obs_active bit clears, no wrap to ~1020.
- Force gap_cnt to reach gap_target with slots 0,1 active -> slot 2 loads obs_h=640 and obs_v=400 or 360 per lfsr[7]; gap_cnt=0. With all 4 slots full -> no load, gap_target reloaded.
- Dino box (h=90,v=380,w=20,ht=30) vs ground obs at h=100 -> collide=1 for 1 clk, alive=0, obs_h frozen through further ticks; obs at h=110 (edges touch) -> no collision.
- DEAD, start=1 -> all slots cleared, RUN, alive=1; start asserted during RUN has no effect.
- With OBS_PAUSE_EN defined: pause=1 across 10 ticks -> obs_h and gap_cnt unchanged; an overlap during the pause still produces DEAD.
